// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, with a latched bit period per frame.
// Define UART_TRANSMITTER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [14:0]                   clks_per_bit_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_byte_i,
    output logic                          tx_ready_o,
    output logic                          tx_serial_o,
    output logic                          tx_active_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TRANSMITTER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ready_q, ready_d;
    logic [7:0]      shift_q, shift_d;
    logic [14:0]     period_q, period_d;
    logic [14:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            serial_q, serial_d;
    logic            active_q, active_d;
    logic            frame_end_q, frame_end_d;
    logic            done_q, done_d;
`ifdef UART_TRANSMITTER_PARITY_EN
    logic            parity_q, parity_d;
`endif
    logic            push;
    logic            pop;
    logic            bit_last;
    logic [14:0]     clamped;

    always_comb begin
        push        = tx_valid_i && ready_q;
        pop         = 1'b0;
        bit_last    = (cnt_q == period_q - 15'd1);
        clamped     = (clks_per_bit_i < 15'd2) ? 15'd2 : clks_per_bit_i;
        state_d     = state_q;
        shift_d     = shift_q;
        period_d    = period_q;
        cnt_d       = bit_last ? '0 : cnt_q + 15'd1;
        idx_d       = idx_q;
        frame_end_d = 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (level_q != '0) pop = 1'b1;
            end
            START: begin
                if (bit_last) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TRANSMITTER_PARITY_EN
            PARITY: begin
                if (bit_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_last) begin
                    frame_end_d = 1'b1;
                    if (level_q != '0) pop = 1'b1;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            period_d = clamped;
            cnt_d    = '0;
            state_d  = START;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        ready_d  = (level_d != DEPTH_L);

        // Line outputs are registered from the current state, so they trail the FSM by one cycle;
        // the done pulse is delayed twice to land just after the stop bit as seen on the line.
        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
`ifdef UART_TRANSMITTER_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            default: serial_d = 1'b1;
        endcase
        active_d = (state_q != IDLE);
        done_d   = frame_end_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            shift_q     <= '0;
            period_q    <= 15'd2;
            cnt_q       <= '0;
            idx_q       <= '0;
            serial_q    <= 1'b1;
            active_q    <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            shift_q     <= shift_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            serial_q    <= serial_d;
            active_q    <= active_d;
            frame_end_q <= frame_end_d;
            done_q      <= done_d;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= tx_byte_i;
    end

    assign tx_ready_o   = ready_q;
    assign tx_serial_o  = serial_q;
    assign tx_active_o  = active_q;
    assign tx_done_o    = done_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter (FIFO_DEPTH=4); the parity frame is exercised when
// UART_TRANSMITTER_PARITY_EN is defined.
module tb_uart_transmitter;

`ifdef UART_TRANSMITTER_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic        clock;
    logic        reset;
    logic [14:0] clks_per_bit;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;
    logic [2:0]  fifo_level;

    int unsigned n_checks;
    int unsigned n_fail;

    uart_transmitter #(.FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .clks_per_bit_i (clks_per_bit),
        .tx_valid_i     (tx_valid),
        .tx_byte_i      (tx_byte),
        .tx_ready_o     (tx_ready),
        .tx_serial_o    (tx_serial),
        .tx_active_o    (tx_active),
        .tx_done_o      (tx_done),
        .fifo_level_o   (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the first line cycle of a start bit; returns at the first cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input int unsigned n, input string tag);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_TRANSMITTER_PARITY_EN
        bits[9] = ^b;
`endif
        for (int unsigned i = 0; i < FRAME_BITS; i++) begin
            for (int unsigned c = 0; c < n; c++) begin
                chk({tag, "_serial"}, 32'(tx_serial), 32'(bits[i]));
                chk({tag, "_active"}, 32'(tx_active), 32'd1);
                if (i != 0 || c != 0) chk({tag, "_done_low"}, 32'(tx_done), 32'd0);
                tick();
            end
        end
    endtask

    // Single push into an idle, empty block; returns at the first cycle of the start bit.
    task automatic send_one(input logic [7:0] b, input string tag);
        tx_byte  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk({tag, "_level1"}, 32'(fifo_level), 32'd1);
        chk({tag, "_idle_e0"}, 32'(tx_serial), 32'd1);
        tick();
        chk({tag, "_idle_e1"}, 32'(tx_serial), 32'd1);
        tick();
    endtask

    logic [7:0] q6 [6];
    int unsigned wait_cnt;
    logic saw_done;
    logic saw_low;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        clks_per_bit = 15'd4;
        tx_valid     = 1'b0;
        tx_byte      = 8'h00;
        q6[0] = 8'h3C; q6[1] = 8'hC3; q6[2] = 8'h5A;
        q6[3] = 8'hA5; q6[4] = 8'h0F; q6[5] = 8'hF0;

        tick();
        tick();
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_active", 32'(tx_active), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b0;
        tick();

        // 0x55 at N=4: 40-cycle frame, done at cycle 40
        clks_per_bit = 15'd4;
        send_one(8'h55, "f55");
        check_frame(8'h55, 4, "f55");
        chk("f55_done", 32'(tx_done), 32'd1);
        tick();
        chk("f55_done_once", 32'(tx_done), 32'd0);
        chk("f55_idle_active", 32'(tx_active), 32'd0);
        chk("f55_idle_serial", 32'(tx_serial), 32'd1);
        tick();

        // three pushes on consecutive cycles at N=2, frames back to back
        clks_per_bit = 15'd2;
        tx_valid = 1'b1;
        tx_byte = 8'h01; tick();
        tx_byte = 8'h80; tick();
        chk("b2b_level_after2", 32'(fifo_level), 32'd1);
        tx_byte = 8'hFF; tick();
        tx_valid = 1'b0;
        chk("b2b_level_after3", 32'(fifo_level), 32'd2);
        check_frame(8'h01, 2, "b2b_01");
        chk("b2b_done1", 32'(tx_done), 32'd1);
        check_frame(8'h80, 2, "b2b_80");
        chk("b2b_done2", 32'(tx_done), 32'd1);
        check_frame(8'hFF, 2, "b2b_FF");
        chk("b2b_done3", 32'(tx_done), 32'd1);
        chk("b2b_level_end", 32'(fifo_level), 32'd0);
        tick();
        chk("b2b_done_end", 32'(tx_done), 32'd0);
        chk("b2b_active_end", 32'(tx_active), 32'd0);
        tick();

        // FIFO full: 6 bytes with valid held high at N=10
        clks_per_bit = 15'd10;
        tx_valid = 1'b1;
        tx_byte = q6[0]; tick();
        chk("full_lvl_a", 32'(fifo_level), 32'd1);
        tx_byte = q6[1]; tick();
        chk("full_lvl_b", 32'(fifo_level), 32'd1);
        tx_byte = q6[2]; tick();
        chk("full_lvl_c", 32'(fifo_level), 32'd2);
        chk("full_start_b0", 32'(tx_serial), 32'd0);
        tx_byte = q6[3]; tick();
        chk("full_lvl_d", 32'(fifo_level), 32'd3);
        chk("full_ready_d", 32'(tx_ready), 32'd1);
        tx_byte = q6[4]; tick();
        chk("full_lvl_e", 32'(fifo_level), 32'd4);
        chk("full_ready_low", 32'(tx_ready), 32'd0);
        tx_byte = q6[5];
        wait_cnt = 0;
        while (tx_ready !== 1'b1 && wait_cnt < 300) begin
            tick();
            wait_cnt++;
        end
        chk("full_ready_wait", wait_cnt, 32'd97);
        chk("full_lvl_after_pop", 32'(fifo_level), 32'd3);
        tick();
        tx_valid = 1'b0;
        chk("full_lvl_refill", 32'(fifo_level), 32'd4);
        chk("full_ready_low2", 32'(tx_ready), 32'd0);
        chk("full_done_b0", 32'(tx_done), 32'd1);
        for (int unsigned k = 1; k < 6; k++) begin
            check_frame(q6[k], 10, "full_frame");
            chk("full_done_k", 32'(tx_done), 32'd1);
        end
        chk("full_lvl_end", 32'(fifo_level), 32'd0);
        tick();
        chk("full_active_end", 32'(tx_active), 32'd0);

        // reset during data bit 3 of 0xA5 with two bytes queued
        clks_per_bit = 15'd4;
        tx_valid = 1'b1;
        tx_byte = 8'hA5; tick();
        tx_byte = 8'h3C; tick();
        tx_byte = 8'h7E; tick();
        tx_valid = 1'b0;
        chk("rmid_level", 32'(fifo_level), 32'd2);
        for (int unsigned k = 0; k < 17; k++) tick();
        chk("rmid_bit3_low", 32'(tx_serial), 32'd0);
        reset = 1'b1;
        #1;
        chk("rmid_serial_async", 32'(tx_serial), 32'd1);
        chk("rmid_level_async", 32'(fifo_level), 32'd0);
        chk("rmid_active_async", 32'(tx_active), 32'd0);
        chk("rmid_ready_async", 32'(tx_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        saw_done = 1'b0;
        saw_low  = 1'b0;
        for (int unsigned k = 0; k < 60; k++) begin
            tick();
            if (tx_done === 1'b1) saw_done = 1'b1;
            if (tx_serial !== 1'b1) saw_low = 1'b1;
        end
        chk("rmid_no_done", 32'(saw_done), 32'd0);
        chk("rmid_line_idle", 32'(saw_low), 32'd0);
        chk("rmid_level_after", 32'(fifo_level), 32'd0);

        // first push after reset, then N changes mid-frame (4 -> 8)
        clks_per_bit = 15'd4;
        tx_valid = 1'b1;
        tx_byte = 8'h96; tick();
        chk("nchg_idle_e0", 32'(tx_serial), 32'd1);
        tx_byte = 8'h69; tick();
        tx_valid = 1'b0;
        chk("nchg_idle_e1", 32'(tx_serial), 32'd1);
        chk("nchg_level", 32'(fifo_level), 32'd1);
        tick();
        clks_per_bit = 15'd8;
        check_frame(8'h96, 4, "nchg_96");
        chk("nchg_done1", 32'(tx_done), 32'd1);
        check_frame(8'h69, 8, "nchg_69");
        chk("nchg_done2", 32'(tx_done), 32'd1);
        tick();
        chk("nchg_active_end", 32'(tx_active), 32'd0);

        // periods below 2 behave as 2
        clks_per_bit = 15'd0;
        send_one(8'hC4, "clamp0");
        check_frame(8'hC4, 2, "clamp0");
        chk("clamp0_done", 32'(tx_done), 32'd1);
        tick();
        clks_per_bit = 15'd1;
        send_one(8'h3A, "clamp1");
        check_frame(8'h3A, 2, "clamp1");
        chk("clamp1_done", 32'(tx_done), 32'd1);
        tick();

`ifdef UART_TRANSMITTER_PARITY_EN
        clks_per_bit = 15'd3;
        send_one(8'h07, "par07");
        check_frame(8'h07, 3, "par07");
        chk("par07_done", 32'(tx_done), 32'd1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
